// File: rtl/acc_buf_rmw.sv
// Accumulation buffer with pipelined read-modify-write.
// Takes per-cycle accumulate commands (address, lane mask, new flag) plus MAC partial sums,
// and updates a BATCH-lane accumulator memory one word per cycle. Also provides a drain read
// port and a whole-memory clear sweep.
// Build option: define ACC_SAT_EN so lane adds saturate and the sticky ovf flag is driven;
// when it is undefined, adds wrap and ovf is tied low.
module acc_buf_rmw #(
    parameter int unsigned ADDR_W = 8,
    parameter int unsigned BATCH  = 32,
    parameter int unsigned ACC_W  = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [ADDR_W-1:0]        acc_addr,
    input  logic [BATCH-1:0]         acc_en,
    input  logic                     acc_new,
    input  logic [BATCH*ACC_W-1:0]   acc_data,
    input  logic                     rd_en,
    input  logic [ADDR_W-1:0]        rd_addr,
    output logic                     rd_ready,
    output logic                     rd_valid,
    output logic [BATCH*ACC_W-1:0]   rd_data,
    input  logic                     clr,
    output logic                     busy,
    output logic                     ovf
);

    localparam int unsigned DEPTH  = 2 ** ADDR_W;
    localparam int unsigned WORD_W = BATCH * ACC_W;

    typedef enum logic {StIdle, StClear} state_e;

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   clr_cnt_q, clr_cnt_d;

    logic [WORD_W-1:0]   mem [DEPTH];
    logic [WORD_W-1:0]   rdata_q;

    // Accumulate stage: the command whose read came back and whose result is written this cycle.
    logic                s1_valid_q;
    logic [ADDR_W-1:0]   s1_addr_q;
    logic [BATCH-1:0]    s1_en_q;
    logic                s1_new_q;
    logic [WORD_W-1:0]   s1_data_q;

    // Drain pipeline.
    logic                rd_s1_q;
    logic                rd_valid_q;
    logic [WORD_W-1:0]   rd_data_q;

    logic                is_idle;
    logic                acc_accept;
    logic                rd_accept;
    logic                rd_fire;
    logic [ADDR_W-1:0]   raddr;
    logic                fwd_hit;
    logic [WORD_W-1:0]   wr_word;
    logic [ACC_W-1:0]    old_l;
    logic [ACC_W-1:0]    in_l;
    logic [ACC_W-1:0]    sum_l;

`ifdef ACC_SAT_EN
    logic [ACC_W:0]      wide_l;
    logic [BATCH-1:0]    lane_sat;
    logic                ovf_q;
`endif

    assign is_idle    = (state_q == StIdle);
    // clr in the same cycle as a command wins; the command is dropped.
    assign acc_accept = is_idle && (|acc_en) && !clr;
    assign rd_ready   = is_idle && (acc_en == '0);
    assign rd_accept  = rd_ready && rd_en;

    // Accumulate and drain never issue in the same cycle, so one read port serves both.
    assign rd_fire = acc_accept || rd_accept;
    assign raddr   = acc_accept ? acc_addr : rd_addr;

    // The stage-1 word is written on the same edge this read samples memory, so take it directly.
    assign fwd_hit = s1_valid_q && (s1_addr_q == raddr);

    // Clear-sweep FSM: next state and sweep address.
    always_comb begin
        state_d   = state_q;
        clr_cnt_d = clr_cnt_q;
        case (state_q)
            StIdle: begin
                if (clr) begin
                    state_d   = StClear;
                    clr_cnt_d = '0;
                end
            end
            StClear: begin
                if (clr) begin
                    clr_cnt_d = '0;
                end else if (&clr_cnt_q) begin
                    state_d = StIdle;
                end else begin
                    clr_cnt_d = clr_cnt_q + ADDR_W'(1);
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= StIdle;
            clr_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            clr_cnt_q <= clr_cnt_d;
        end
    end

    // Per-lane modify: overwrite or add (wrapping or saturating), masked lanes keep old value.
    always_comb begin
        wr_word = rdata_q;
        old_l   = '0;
        in_l    = '0;
        sum_l   = '0;
`ifdef ACC_SAT_EN
        wide_l   = '0;
        lane_sat = '0;
`endif
        for (int i = 0; i < BATCH; i++) begin
            old_l = rdata_q[i*ACC_W +: ACC_W];
            in_l  = s1_data_q[i*ACC_W +: ACC_W];
            sum_l = old_l + in_l;
`ifdef ACC_SAT_EN
            wide_l = {old_l[ACC_W-1], old_l} + {in_l[ACC_W-1], in_l};
            if (wide_l[ACC_W] != wide_l[ACC_W-1]) begin
                sum_l = wide_l[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
                if (s1_en_q[i] && !s1_new_q) begin
                    lane_sat[i] = 1'b1;
                end
            end
`endif
            if (s1_en_q[i]) begin
                wr_word[i*ACC_W +: ACC_W] = s1_new_q ? in_l : sum_l;
            end
        end
    end

    // Memory: clear sweep or masked RMW write, plus the registered (forwarded) read.
    always_ff @(posedge clk) begin
        if (state_q == StClear) begin
            mem[clr_cnt_q] <= '0;
        end else if (s1_valid_q) begin
            mem[s1_addr_q] <= wr_word;
        end
        if (rd_fire) begin
            rdata_q <= fwd_hit ? wr_word : mem[raddr];
        end
    end

    // Accumulate command pipeline register; reset drops anything in flight.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1_valid_q <= 1'b0;
            s1_addr_q  <= '0;
            s1_en_q    <= '0;
            s1_new_q   <= 1'b0;
            s1_data_q  <= '0;
        end else begin
            s1_valid_q <= acc_accept;
            if (acc_accept) begin
                s1_addr_q <= acc_addr;
                s1_en_q   <= acc_en;
                s1_new_q  <= acc_new;
                s1_data_q <= acc_data;
            end
        end
    end

    // Drain pipeline: read data lands in rdata_q, then is held on rd_data with a one-cycle valid.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_s1_q    <= 1'b0;
            rd_valid_q <= 1'b0;
            rd_data_q  <= '0;
        end else begin
            rd_s1_q    <= rd_accept;
            rd_valid_q <= rd_s1_q;
            if (rd_s1_q) begin
                rd_data_q <= rdata_q;
            end
        end
    end

`ifdef ACC_SAT_EN
    // Sticky overflow flag, cleared by reset or a clear request.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ovf_q <= 1'b0;
        end else if (clr) begin
            ovf_q <= 1'b0;
        end else if (s1_valid_q && (|lane_sat)) begin
            ovf_q <= 1'b1;
        end
    end

    assign ovf = ovf_q;
`else
    assign ovf = 1'b0;
`endif

    assign rd_valid = rd_valid_q;
    assign rd_data  = rd_data_q;
    assign busy     = (state_q == StClear) || s1_valid_q || rd_s1_q;

endmodule

// File: tb/tb_acc_buf_rmw.sv
// Self-checking bench for acc_buf_rmw: a reference memory model tracks every accepted
// command, expected drain words are queued at read acceptance and compared on rd_valid.
module tb_acc_buf_rmw;

    localparam int unsigned AW    = 8;
    localparam int unsigned NB    = 32;
    localparam int unsigned ACC   = 32;
    localparam int unsigned W     = NB * ACC;
    localparam int unsigned DEPTH = 2 ** AW;
    localparam longint MAXV = (longint'(1) <<< (ACC - 1)) - 1;
    localparam longint MINV = -(longint'(1) <<< (ACC - 1));

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [AW-1:0]   acc_addr = '0;
    logic [NB-1:0]   acc_en = '0;
    logic            acc_new = 1'b0;
    logic [W-1:0]    acc_data = '0;
    logic            rd_en = 1'b0;
    logic [AW-1:0]   rd_addr = '0;
    logic            rd_ready;
    logic            rd_valid;
    logic [W-1:0]    rd_data;
    logic            clr = 1'b0;
    logic            busy;
    logic            ovf;

    acc_buf_rmw #(
        .ADDR_W (AW),
        .BATCH  (NB),
        .ACC_W  (ACC)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .acc_addr (acc_addr),
        .acc_en   (acc_en),
        .acc_new  (acc_new),
        .acc_data (acc_data),
        .rd_en    (rd_en),
        .rd_addr  (rd_addr),
        .rd_ready (rd_ready),
        .rd_valid (rd_valid),
        .rd_data  (rd_data),
        .clr      (clr),
        .busy     (busy),
        .ovf      (ovf)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] data;
        int           cyc;
    } sb_t;

    sb_t          sb_q[$];
    sb_t          sb_e;
    logic [W-1:0] model [DEPTH];
    int           cyc = 0;
    int           checks = 0;
    int           errors = 0;
    logic         exp_ovf;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        int lane;
        checks++;
        if (got !== exp) begin
            errors++;
            lane = 0;
            for (int i = NB - 1; i >= 0; i--) begin
                if (got[i*ACC +: ACC] !== exp[i*ACC +: ACC]) lane = i;
            end
            $display("FAIL %s: lane %0d got 0x%h expected 0x%h", tag, lane,
                     got[lane*ACC +: ACC], exp[lane*ACC +: ACC]);
        end
    endtask

    // Scoreboard consumer: every rd_valid pulse must match the oldest accepted read.
    always @(negedge clk) begin
        if (rst && rd_valid) begin
            if (sb_q.size() == 0) begin
                check("rd_valid_unexpected", 1, 0);
            end else begin
                sb_e = sb_q.pop_front();
                check("rd_data", rd_data, sb_e.data);
                check("rd_latency", W'(cyc - sb_e.cyc), W'(2));
            end
        end
    end

    function automatic logic [ACC-1:0] lane_add(input logic [ACC-1:0] a, input logic [ACC-1:0] b);
        longint s;
        s = longint'($signed(a)) + longint'($signed(b));
`ifdef ACC_SAT_EN
        if (s > MAXV) s = MAXV;
        if (s < MINV) s = MINV;
`endif
        return s[ACC-1:0];
    endfunction

    function automatic void model_apply(input logic [AW-1:0] a, input logic [NB-1:0] en,
                                        input logic nw, input logic [W-1:0] d);
        logic [W-1:0] w;
        w = model[a];
        for (int i = 0; i < NB; i++) begin
            if (en[i]) w[i*ACC +: ACC] = nw ? d[i*ACC +: ACC] : lane_add(w[i*ACC +: ACC], d[i*ACC +: ACC]);
        end
        model[a] = w;
    endfunction

    function automatic logic [W-1:0] fill(input logic [ACC-1:0] v);
        logic [W-1:0] w;
        for (int i = 0; i < NB; i++) w[i*ACC +: ACC] = v;
        return w;
    endfunction

    function automatic logic [W-1:0] rand_word();
        logic [W-1:0] w;
        for (int i = 0; i < NB; i++) w[i*ACC +: ACC] = ACC'($urandom);
        return w;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Drive one accepted accumulate for one cycle; acc_en stays set for back-to-back use.
    task automatic acc(input logic [AW-1:0] a, input logic [NB-1:0] en, input logic nw,
                       input logic [W-1:0] d);
        acc_addr = a;
        acc_en   = en;
        acc_new  = nw;
        acc_data = d;
        model_apply(a, en, nw, d);
        step();
    endtask

    task automatic acc_idle();
        acc_en   = '0;
        acc_new  = 1'b0;
        acc_data = '0;
    endtask

    task automatic rd(input logic [AW-1:0] a);
        int n;
        n = 0;
        rd_en   = 1'b1;
        rd_addr = a;
        #1;
        while (!rd_ready && n < 50) begin
            step();
            n++;
        end
        if (rd_ready) begin
            sb_q.push_back('{data: model[a], cyc: cyc});
            step();
        end else begin
            check("rd_accept_timeout", 0, 1);
        end
        rd_en = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sb_q.size() != 0 && n < 20) begin
            step();
            n++;
        end
        check("drain_timeout", W'(sb_q.size()), 0);
    endtask

    task automatic do_clear();
        int n;
        clr = 1'b1;
        step();
        clr = 1'b0;
        check("busy_in_clear", busy, 1);
        n = 0;
        while (busy && n < 400) begin
            step();
            n++;
        end
        check("clear_cycles", W'(n), W'(DEPTH));
        for (int i = 0; i < DEPTH; i++) model[i] = '0;
    endtask

    initial begin
        logic [NB-1:0] en;
        int            op;
        // Reset state.
        #2 rst = 1'b0;
        #1;
        check("rst_rd_valid", rd_valid, 0);
        check("rst_rd_data", rd_data, '0);
        check("rst_busy", busy, 0);
        check("rst_ovf", ovf, 0);
        check("rst_rd_ready", rd_ready, 1);
        #10 rst = 1'b1;
        step();

        // Clear sweep, then drain both ends of memory.
        do_clear();
        check("clear_ovf", ovf, 0);
        rd(0);
        rd(AW'(DEPTH - 1));
        drain();

        // New then three back-to-back adds to one address.
        acc(5, '1, 1'b1, fill(7));
        acc(5, '1, 1'b0, fill(1));
        acc(5, '1, 1'b0, fill(2));
        acc(5, '1, 1'b0, fill(3));
        acc_idle();
        check("model_sum13", model[5], fill(13));
        rd(5);
        drain();

        // Single-lane mask over an all-lanes word, issued back to back.
        acc(9, '1, 1'b1, fill(50));
        acc(9, NB'(1), 1'b0, fill(100));
        acc_idle();
        rd(9);
        acc(200, '1, 1'b1, fill(32'hA5A5_0001));
        acc(30, '1, 1'b1, fill(11));
        acc_idle();
        drain();

        // Held drain request blocked by four accumulates, accepted on the fifth cycle.
        rd_en   = 1'b1;
        rd_addr = 9;
        for (int k = 0; k < 4; k++) begin
            acc_addr = 9;
            acc_en   = '1;
            acc_new  = 1'b0;
            acc_data = fill(ACC'(k + 1));
            model_apply(9, '1, 1'b0, fill(ACC'(k + 1)));
            #1;
            check("rd_ready_blocked", rd_ready, 0);
            @(posedge clk);
            #1;
        end
        acc_idle();
        #1;
        check("rd_ready_after", rd_ready, 1);
        sb_q.push_back('{data: model[9], cyc: cyc});
        step();
        rd_en = 1'b0;
        drain();

        // Overflow at both ends of the signed range.
        check("ovf_before", ovf, 0);
        acc(20, '1, 1'b1, fill(32'h7FFF_FFFF));
        acc(20, '1, 1'b0, fill(1));
        acc(21, '1, 1'b1, fill(32'h8000_0000));
        acc(21, '1, 1'b0, fill(32'hFFFF_FFFF));
        acc_idle();
        step();
        step();
`ifdef ACC_SAT_EN
        exp_ovf = 1'b1;
`else
        exp_ovf = 1'b0;
`endif
        check("ovf_after", ovf, W'(exp_ovf));
        rd(20);
        rd(21);
        drain();

        // Random mix over a small address set to stress same-address hazards.
        for (int a = 40; a < 44; a++) acc(AW'(a), '1, 1'b1, rand_word());
        for (int k = 0; k < 80; k++) begin
            op = int'($urandom_range(0, 4));
            if (op == 0) begin
                acc_idle();
                rd(AW'(40 + $urandom_range(0, 3)));
            end else begin
                en = (op == 1) ? '1 : NB'($urandom);
                acc(AW'(40 + $urandom_range(0, 3)), en, ($urandom_range(0, 7) == 0), rand_word());
            end
        end
        acc_idle();
        rd(40);
        rd(41);
        rd(42);
        rd(43);
        drain();

        // Reset with a command in flight: no write may land.
        rd(30);
        drain();
        acc_addr = 30;
        acc_en   = '1;
        acc_new  = 1'b0;
        acc_data = fill(5);
        step();
        acc_idle();
        rst = 1'b0;
        #1;
        check("rstmid_busy", busy, 0);
        check("rstmid_rd_data", rd_data, '0);
        check("rstmid_rd_valid", rd_valid, 0);
        check("rstmid_ovf", ovf, 0);
        #13 rst = 1'b1;
        step();
        check("rstmid_busy_after", busy, 0);
        rd(30);
        drain();

        // Reset during a clear sweep.
        clr = 1'b1;
        step();
        clr = 1'b0;
        for (int k = 0; k < 10; k++) step();
        check("rstclr_busy_before", busy, 1);
        rst = 1'b0;
        #1;
        check("rstclr_busy", busy, 0);
        check("rstclr_rd_valid", rd_valid, 0);
        #13 rst = 1'b1;
        step();
        check("rstclr_busy_after", busy, 0);
        check("rstclr_rd_ready", rd_ready, 1);
        rd(30);
        rd(200);
        drain();

        // Final full clear wipes everything and the sticky flag.
        do_clear();
        check("final_ovf", ovf, 0);
        rd(5);
        rd(40);
        rd(200);
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1);
    end

endmodule

// File: doc/acc_buf_rmw.md
Name: acc_buf_rmw

Overview:
Accumulation buffer stage directly downstream of the conv address generator. Consumes the per-cycle accumulate command (address, per-lane enable mask, new-accumulation flag) together with the MAC array partial sums, and performs a pipelined read-modify-write into a BATCH-lane accumulator memory. Provides a drain read port for the output write-back stage and a bulk clear sweep. Keeps coherence across back-to-back hits to the same address.

Parameters:
ADDR_W, 8, accumulator address width; memory depth = 2**ADDR_W words
BATCH, 32, number of lanes per word; one enable bit per lane
ACC_W, 32, signed accumulator width per lane

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-low
acc_addr  in  ADDR_W  accumulate word address
acc_en  in  BATCH  per-lane accumulate enable; command valid when any bit set
acc_new  in  1  1: enabled lanes are overwritten with acc_data; 0: added to the stored value
acc_data  in  BATCH*ACC_W  signed partial sums, lane i at bits [i*ACC_W +: ACC_W]
rd_en  in  1  drain read request
rd_addr  in  ADDR_W  drain read address
rd_ready  out  1  drain request is accepted this cycle
rd_valid  out  1  rd_data valid
rd_data  out  BATCH*ACC_W  drained word
clr  in  1  single-cycle pulse: zero the entire memory
busy  out  1  clear sweep active or any command in flight
ovf  out  1  sticky lane overflow flag (ACC_SAT_EN only; tied to 0 otherwise)

Behaviour:
- Reset (rst=0, async): rd_valid=0, rd_data=0, busy=0, ovf=0, pipeline valids cleared, FSM to IDLE. Memory contents are not cleared; the first write of each word uses acc_new=1 or is preceded by clr. A reset mid-operation drops every in-flight command with no memory write.
- FSM states:
  - IDLE -> CLEAR on clr.
  - CLEAR sweeps the address counter 0..2**ADDR_W-1, writing all-zero words at one word per cycle; returns to IDLE the cycle after the last address is written.
  - Commands arriving in CLEAR are ignored; rd_ready=0 in CLEAR.
  - clr arriving in CLEAR restarts the sweep at address 0.
- Accumulate pipeline, command accepted at cycle T whenever the FSM is IDLE:
  - T: registered memory read issued.
  - T+1: per lane, new = acc_new ? acc_data : stored + acc_data, wrapping at ACC_W bits (two's complement).
  - T+1 edge: word written with a per-lane mask; disabled lanes keep their old value.
  - Sustained throughput: 1 command per cycle.
- Coherence:
  - Every read observes all previously accepted writes, including those still in flight.
  - A command at T+1 to the same address as the command at T must forward the T result lane-by-lane for lanes that T enabled. Other lanes come from memory.
  - Back-to-back same-address streams of any length must produce an exact sum.
- Drain port:
  - rd_ready = IDLE && acc_en==0. Accumulation has priority.
  - rd_en while rd_ready=0 is dropped; the requester holds rd_en until it sees rd_ready.
  - An accepted read at T gives rd_valid=1 at T+2 with data held on rd_data. rd_valid is a 1-cycle pulse per read.
  - Reads honour the same forwarding as accumulates.
  - Drain reads are non-destructive.
- busy = CLEAR || any pipeline stage valid || drain read in flight.
- Simultaneous clr and acc_en in IDLE: the command is dropped and the clear starts.

Optional Feature:
ACC_SAT_EN:
- Defined: each lane add saturates to [-2**(ACC_W-1), 2**(ACC_W-1)-1]. ovf is set on any saturation of an enabled lane and cleared only by reset or clr.
- Undefined: adds wrap modulo 2**ACC_W and ovf is constant 0.
- Latency is identical in both builds.

Test Plan:
- Reset, then clr; wait for busy=0 (256 cycles + 1 at ADDR_W=8); drain addr 0 and 255 -> rd_data all zero, rd_valid exactly 2 cycles after acceptance.
- acc_new=1, addr 5, all lanes = 7; then 3 back-to-back acc_new=0 to addr 5 with lane data 1,2,3 -> drain gives 13 per lane, proving T/T+1 forwarding.
- acc_en=0x0000_0001, addr 9, data 100 over a prior all-lanes 50 -> lane0=150, lanes 1..31 remain 50.
- rd_en held while 4 consecutive accumulates arrive -> rd_ready=0 for those 4 cycles, read accepted on the 5th, and the returned data includes all 4 updates.
- Lane at 0x7FFF_FFFF plus 1 -> reads 0x8000_0000 with ovf=0 (feature off); reads 0x7FFF_FFFF with ovf=1 (ACC_SAT_EN).
- rst asserted while the pipeline is full and during a CLEAR sweep -> outputs go to 0 immediately; after release, busy=0 and no stray write is observed at the target address.
